// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR SDRAM device model: command codes, mode-register
// field positions, burst-length / CAS-latency decode and bank state.
package sdr_pkg;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    typedef enum logic [1:0] {
        BURST_IDLE  = 2'd0,
        BURST_READ  = 2'd1,
        BURST_WRITE = 2'd2
    } burst_state_e;

    localparam int MR_BT_BIT = 3;
    localparam int MR_WB_BIT = 9;
    localparam int AP_BIT    = 10;

    // Low-order column bits that wrap inside a burst; unknown codes behave as BL=1.
    function automatic logic [2:0] bl_mask(input logic [2:0] code);
        case (code)
            3'd1:    return 3'd1;
            3'd2:    return 3'd3;
            3'd3:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic bl_full(input logic [2:0] code);
        return code == 3'd7;
    endfunction

    function automatic logic cl_is2(input logic [2:0] code);
        return code == 3'd2;
    endfunction

endpackage

// File: rtl/sdr_burst_addr.sv
// Column address generator for one burst beat: sequential or interleaved inside
// the burst-aligned block, or free-running wrap across the row for full page.
module sdr_burst_addr
    import sdr_pkg::*;
#(
    parameter int COL_BITS = 9
) (
    input  logic [COL_BITS-1:0] start_col,
    input  logic [2:0]          bl_code,
    input  logic                burst_type,
    input  logic [COL_BITS-1:0] beat,
    output logic [COL_BITS-1:0] col,
    output logic                last
);

    logic                full;
    logic [COL_BITS-1:0] mask;
    logic [COL_BITS-1:0] offs;

    always_comb begin
        full = bl_full(bl_code);
        mask = full ? '1 : COL_BITS'(bl_mask(bl_code));
        offs = (burst_type && !full) ? (start_col ^ beat) : (start_col + beat);
        col  = (start_col & ~mask) | (offs & mask);
        last = !full && (beat == mask);
    end

endmodule

// File: rtl/sdr_sdram.sv
// Cycle-accurate single-rank SDR SDRAM device model with per-bank open rows,
// programmable burst and CAS latency, and a tri-stated Dq bus.
//
// state        | meaning
// BURST_IDLE   | no burst in flight
// BURST_READ   | issuing read beats into the CAS-latency pipeline
// BURST_WRITE  | storing write beats sampled from Dq
module sdr_sdram
    import sdr_pkg::*;
#(
    parameter int ADDR_BITS = 13,
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 9,
    parameter int BA_BITS   = 2,
    parameter int DQ_BITS   = 16,
    parameter int DM_BITS   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Cke,
    input  logic                 Cs_n,
    input  logic                 Ras_n,
    input  logic                 Cas_n,
    input  logic                 We_n,
    input  logic [ADDR_BITS-1:0] Addr,
    input  logic [BA_BITS-1:0]   Ba,
    inout  wire  [DQ_BITS-1:0]   Dq,
    input  logic [DM_BITS-1:0]   Dqm
);

    localparam int BANKS    = 1 << BA_BITS;
    localparam int MEM_BITS = BA_BITS + ROW_BITS + COL_BITS;

    logic [DQ_BITS-1:0]  mem [0:(1<<MEM_BITS)-1];
    bank_state_e         bank_state   [BANKS];
    bank_state_e         bank_state_n [BANKS];
    logic [ROW_BITS-1:0] bank_row     [BANKS];

    logic [2:0] mode_bl;
    logic       mode_bt, mode_cl2, mode_wb;

    burst_state_e        state, state_n;
    logic [BA_BITS-1:0]  b_bank;
    logic [ROW_BITS-1:0] b_row;
    logic [COL_BITS-1:0] b_start, b_beat;
    logic                b_ap;

    cmd_e                cmd;
    logic                cmd_en, all_idle, busy, rw_ok, stop, abort;
    logic                iss, iss_wr, iss_ap, iss_last;
    logic [BA_BITS-1:0]  iss_bank;
    logic [ROW_BITS-1:0] iss_row;
    logic [COL_BITS-1:0] iss_start, iss_beat, iss_col;
    logic [2:0]          iss_code;
    logic [MEM_BITS-1:0] iss_addr;

    logic [DQ_BITS-1:0]  p0, p1, out_d;
    logic                p0_v, p1_v;
    logic [DM_BITS-1:0]  out_oe, dqm_q;

    assign cmd      = cmd_e'({Ras_n, Cas_n, We_n});
    assign cmd_en   = Cke && !Cs_n;
    assign iss_code = (iss_wr && mode_wb) ? 3'd0 : mode_bl;
    assign iss_addr = {iss_bank, iss_row, iss_col};

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < BANKS; i++)
            if (bank_state[i] == BANK_ACTIVE) all_idle = 1'b0;
    end

    // A READ/WRITE to the bank whose auto-precharge is still pending is illegal and dropped.
    always_comb begin
        busy  = (state != BURST_IDLE);
        rw_ok = cmd_en && (cmd == CMD_RD || cmd == CMD_WR)
                && bank_state[Ba] == BANK_ACTIVE && !(busy && b_ap && Ba == b_bank);
        stop  = busy && cmd_en
                && (cmd == CMD_BST || (cmd == CMD_PRE && (Addr[AP_BIT] || Ba == b_bank)));
        iss       = 1'b0;
        iss_wr    = (state == BURST_WRITE);
        iss_bank  = b_bank;
        iss_row   = b_row;
        iss_start = b_start;
        iss_beat  = b_beat;
        iss_ap    = b_ap;
        abort     = 1'b0;
        if (rw_ok) begin
            iss       = 1'b1;
            iss_wr    = (cmd == CMD_WR);
            iss_bank  = Ba;
            iss_row   = bank_row[Ba];
            iss_start = Addr[COL_BITS-1:0];
            iss_beat  = '0;
            iss_ap    = Addr[AP_BIT];
            abort     = busy && b_ap;
        end else if (stop) begin
            abort = b_ap;
        end else if (busy && Cke) begin
            iss = 1'b1;
        end
    end

    sdr_burst_addr #(.COL_BITS(COL_BITS)) u_burst_addr (
        .start_col  (iss_start),
        .bl_code    (iss_code),
        .burst_type (mode_bt),
        .beat       (iss_beat),
        .col        (iss_col),
        .last       (iss_last)
    );

    always_comb begin
        state_n = state;
        if (stop) state_n = BURST_IDLE;
        if (iss)  state_n = iss_last ? BURST_IDLE : (iss_wr ? BURST_WRITE : BURST_READ);
    end

    always_comb begin
        bank_state_n = bank_state;
        if (abort) bank_state_n[b_bank] = BANK_IDLE;
        if (iss && iss_last && iss_ap) bank_state_n[iss_bank] = BANK_IDLE;
        if (cmd_en && cmd == CMD_ACT) bank_state_n[Ba] = BANK_ACTIVE;
        if (cmd_en && cmd == CMD_PRE) begin
            if (Addr[AP_BIT]) begin
                for (int i = 0; i < BANKS; i++) bank_state_n[i] = BANK_IDLE;
            end else begin
                bank_state_n[Ba] = BANK_IDLE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= BURST_IDLE;
            for (int i = 0; i < BANKS; i++) bank_state[i] <= BANK_IDLE;
            mode_bl  <= 3'd0;
            mode_bt  <= 1'b0;
            mode_cl2 <= 1'b0;
            mode_wb  <= 1'b0;
            p0_v     <= 1'b0;
            p1_v     <= 1'b0;
            out_oe   <= '0;
            dqm_q    <= '0;
        end else if (Cke) begin
            state      <= state_n;
            bank_state <= bank_state_n;
            if (cmd_en && cmd == CMD_ACT && bank_state[Ba] == BANK_IDLE)
                bank_row[Ba] <= Addr[ROW_BITS-1:0];
            if (cmd_en && cmd == CMD_LMR && all_idle) begin
                mode_bl  <= Addr[2:0];
                mode_bt  <= Addr[MR_BT_BIT];
                mode_cl2 <= cl_is2(Addr[6:4]);
                mode_wb  <= Addr[MR_WB_BIT];
            end
            if (iss) begin
                b_bank  <= iss_bank;
                b_row   <= iss_row;
                b_start <= iss_start;
                b_beat  <= iss_beat + 1'b1;
                b_ap    <= iss_ap;
            end
            // Read pipeline: p0 -> p1 -> out; CL=2 bypasses p1.
            p0    <= mem[iss_addr];
            p0_v  <= iss && !iss_wr;
            p1    <= p0;
            p1_v  <= p0_v;
            out_d <= mode_cl2 ? p0 : p1;
            for (int i = 0; i < DM_BITS; i++)
                out_oe[i] <= (mode_cl2 ? p0_v : p1_v) && !dqm_q[i];
            dqm_q <= Dqm;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n && iss && iss_wr) begin
            for (int i = 0; i < DM_BITS; i++)
                if (!Dqm[i]) mem[iss_addr][8*i +: 8] <= Dq[8*i +: 8];
        end
    end

    for (genvar g = 0; g < DM_BITS; g++) begin : g_dq
        assign Dq[8*g +: 8] = out_oe[g] ? out_d[8*g +: 8] : 8'bz;
    end

endmodule

// File: tb/tb_sdr_sdram.sv
// Directed bench for sdr_sdram: init, auto-precharge bursts, burst ordering, Dqm,
// BST, reset mid-read and CL=2. Dq is pulled up, so a released bus reads 16'hFFFF.
module tb_sdr_sdram;

    logic        Clk = 1'b0;
    logic        Rst_n, Cke, Cs_n, Ras_n, Cas_n, We_n;
    logic [12:0] Addr;
    logic [1:0]  Ba, Dqm;
    wire  [15:0] Dq;
    logic [15:0] dq_drv;
    logic        dq_en;

    localparam logic [15:0] HIZ = 16'hFFFF;
    localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
    localparam logic [2:0] BST = 3'b110, PRE = 3'b010, REF = 3'b001, LMR = 3'b000;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign Dq = dq_en ? dq_drv : 16'bz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (Dq[i]);
    end

    sdr_sdram dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Cke   (Cke),
        .Cs_n  (Cs_n),
        .Ras_n (Ras_n),
        .Cas_n (Cas_n),
        .We_n  (We_n),
        .Addr  (Addr),
        .Ba    (Ba),
        .Dq    (Dq),
        .Dqm   (Dqm)
    );

    function automatic logic [15:0] dval(input int b, input int k);
        return 16'hA000 + 16'(b * 256 + k);
    endfunction

    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
        Cs_n = 1'b0;
        {Ras_n, Cas_n, We_n} = c;
        Ba   = b;
        Addr = a;
        @(posedge Clk);
        #1;
        Cs_n = 1'b1;
        {Ras_n, Cas_n, We_n} = NOP;
        Ba   = '0;
        Addr = '0;
    endtask

    task automatic nop();
        issue(NOP, 2'd0, 13'd0);
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        checks++;
        assert (Dq === exp) else begin
            errors++;
            $error("FAIL %s: Dq=%h expected %h", tag, Dq, exp);
        end
    endtask

    // Called right after the READ edge T; CL=3 beats are seen after edges T+2..T+5.
    task automatic read_burst(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        nop(); nop(); chk({tag, "_b0"}, e0);
        nop();        chk({tag, "_b1"}, e1);
        nop();        chk({tag, "_b2"}, e2);
        nop();        chk({tag, "_b3"}, e3);
        nop();        chk({tag, "_end"}, HIZ);
    endtask

    task automatic write4(input logic [1:0] b, input int col, input logic ap,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3,
                          input logic [1:0] dqm1);
        dq_en  = 1'b1;
        dq_drv = d0;
        issue(WR, b, 13'(col) | (ap ? 13'h400 : 13'h000));
        dq_drv = d1; Dqm = dqm1;
        nop();
        dq_drv = d2; Dqm = 2'b00;
        nop();
        dq_drv = d3;
        nop();
        dq_en  = 1'b0;
    endtask

    task automatic idle_read(input string tag, input logic [1:0] b);
        issue(RD, b, 13'd0);
        nop(); nop(); chk(tag, HIZ);
        nop();        chk(tag, HIZ);
    endtask

    initial begin
        Rst_n = 1'b0; Cke = 1'b1; Cs_n = 1'b1;
        {Ras_n, Cas_n, We_n} = NOP;
        Addr = '0; Ba = '0; Dqm = '0; dq_drv = '0; dq_en = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_hiz", HIZ);
        Rst_n = 1'b1;

        repeat (10) nop();
        chk("init_nop_hiz", HIZ);
        issue(PRE, 2'd0, 13'd1024);
        issue(REF, 2'd0, 13'd0);
        issue(REF, 2'd0, 13'd0);
        issue(LMR, 2'd0, 13'd50);
        nop();
        chk("init_lmr_hiz", HIZ);

        for (int b = 0; b < 4; b++) begin
            issue(ACT, 2'(b), 13'd0);
            write4(2'(b), 0, 1'b1, dval(b, 0), dval(b, 1), dval(b, 2), dval(b, 3), 2'b00);
        end
        nop();
        idle_read("wr_ap_idle_b0", 2'd0);
        idle_read("wr_ap_idle_b1", 2'd1);
        idle_read("wr_ap_idle_b2", 2'd2);
        idle_read("wr_ap_idle_b3", 2'd3);

        issue(ACT, 2'd0, 13'd0);
        issue(RD, 2'd0, 13'h400);
        read_burst("rd_ap", dval(0, 0), dval(0, 1), dval(0, 2), dval(0, 3));
        idle_read("rd_ap_idle", 2'd0);

        issue(ACT, 2'd0, 13'd0);
        issue(RD, 2'd0, 13'd2);
        read_burst("seq_c2", dval(0, 2), dval(0, 3), dval(0, 0), dval(0, 1));
        issue(PRE, 2'd0, 13'd1024);
        issue(LMR, 2'd0, 13'd58);
        issue(ACT, 2'd0, 13'd0);
        issue(RD, 2'd0, 13'd2);
        read_burst("int_c2", dval(0, 2), dval(0, 3), dval(0, 0), dval(0, 1));
        issue(RD, 2'd0, 13'd1);
        read_burst("int_c1", dval(0, 1), dval(0, 0), dval(0, 3), dval(0, 2));
        issue(PRE, 2'd0, 13'd1024);

        issue(LMR, 2'd0, 13'd50);
        issue(ACT, 2'd2, 13'd0);
        write4(2'd2, 0, 1'b0, 16'h5511, 16'h6622, 16'h5533, 16'h5544, 2'b10);
        nop();
        issue(RD, 2'd2, 13'd0);
        Dqm = 2'b11;
        nop();
        Dqm = 2'b00;
        nop(); chk("dqm_rd_b0", HIZ);
        nop(); chk("dqm_wr_b1", 16'hA222);
        nop(); chk("dqm_b2", 16'h5533);
        nop(); chk("dqm_b3", 16'h5544);
        nop(); chk("dqm_end", HIZ);

        issue(PRE, 2'd0, 13'd1024);
        issue(LMR, 2'd0, 13'd51);
        issue(ACT, 2'd3, 13'd0);
        issue(RD, 2'd3, 13'd0);
        nop();
        issue(BST, 2'd0, 13'd0);
        chk("bst_b0", dval(3, 0));
        nop(); chk("bst_b1", dval(3, 1));
        nop(); chk("bst_stop", HIZ);
        nop(); chk("bst_stop2", HIZ);

        issue(RD, 2'd3, 13'd0);
        nop(); nop(); chk("rst_pre_b0", dval(3, 0));
        Rst_n = 1'b0;
        nop(); chk("rst_mid_hiz", HIZ);
        Rst_n = 1'b1;
        nop(); chk("rst_after_hiz", HIZ);
        idle_read("rst_bank_idle", 2'd3);

        issue(ACT, 2'd0, 13'd0);
        issue(RD, 2'd0, 13'd1);
        nop(); nop(); chk("rst_mode_bl1", dval(0, 1));
        nop();        chk("rst_mode_end", HIZ);

        issue(PRE, 2'd0, 13'd1024);
        issue(LMR, 2'd0, 13'd32);
        issue(ACT, 2'd1, 13'd0);
        issue(RD, 2'd1, 13'd3);
        chk("cl2_early", HIZ);
        nop(); chk("cl2_b0", dval(1, 3));
        nop(); chk("cl2_end", HIZ);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
